cram_load_scheduler: RTL and testbench

//  Sequences bulk loads from DRAM into compute RAMs (CRAMs). Issues word read requests to the

---
 rtl/cram_load_scheduler.sv | 155 +++++++++++++++
 tb/tb_cram_load_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cram_load_scheduler.sv
// Bulk DRAM-to-CRAM loader: issues word reads with bounded outstanding
// requests and streams returned words into successive CRAM addresses.
module cram_load_scheduler #(
  parameter int DWIDTH          = 40,
  parameter int RAM_AWIDTH      = 9,
  parameter int RAM_WORDS       = 512,
  parameter int DRAM_AWIDTH     = 32,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [DRAM_AWIDTH-1:0] dram_base,
  input  logic [31:0]            ram_base_num,
  input  logic [15:0]            num_rams,
  output logic                   rd_req_valid,
  input  logic                   rd_req_ready,
  output logic [DRAM_AWIDTH-1:0] rd_req_addr,
  input  logic                   rd_data_valid,
  input  logic [DWIDTH-1:0]      rd_data,
  output logic [DWIDTH-1:0]      ram_data_out,
  output logic [RAM_AWIDTH-1:0]  ram_addr,
  output logic [31:0]            ram_num,
  output logic                   ram_we,
  output logic                   busy,
  output logic                   done
);

  localparam int TW = 16 + RAM_AWIDTH;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE,
    S_FLUSH
  } state_t;

  state_t                 state;
  logic [DRAM_AWIDTH-1:0] base_q;
  logic [TW-1:0]          total_q;
  logic [TW-1:0]          issued;
  logic [TW-1:0]          returned;
  logic [OW-1:0]          outstanding;

  logic active;
  logic req_fire;
  logic ret_ok;
  logic wr_ok;

  assign active = (state == S_ISSUE) ||
                  (state == S_DRAIN) ||
                  (state == S_FLUSH);

  assign rd_req_valid = (state == S_ISSUE) &&
                        (issued < total_q) &&
                        (outstanding < OW'(MAX_OUTSTANDING)) &&
                        !abort;

  // Address is a pure function of issued, so it holds while stalled.
  assign rd_req_addr = base_q + DRAM_AWIDTH'(issued);

  assign req_fire = rd_req_valid && rd_req_ready;
  assign ret_ok   = rd_data_valid && active &&
                    (outstanding != '0);
  assign wr_ok    = ret_ok && (state != S_FLUSH);

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= S_IDLE;
      base_q       <= '0;
      total_q      <= '0;
      issued       <= '0;
      returned     <= '0;
      outstanding  <= '0;
      ram_data_out <= '0;
      ram_addr     <= '0;
      ram_num      <= '0;
      ram_we       <= 1'b0;
    end else begin
      ram_we <= wr_ok;
      if (wr_ok) begin
        ram_data_out <= rd_data;
        returned     <= returned + TW'(1);
      end

      if (ram_we) begin
        if (ram_addr == RAM_AWIDTH'(RAM_WORDS - 1)) begin
          ram_addr <= '0;
          ram_num  <= ram_num + 32'd1;
        end else begin
          ram_addr <= ram_addr + RAM_AWIDTH'(1);
        end
      end

      if (req_fire) begin
        issued <= issued + TW'(1);
      end

      // Simultaneous issue and return leaves the count unchanged.
      if (req_fire && !ret_ok) begin
        outstanding <= outstanding + OW'(1);
      end else if (!req_fire && ret_ok) begin
        outstanding <= outstanding - OW'(1);
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            base_q      <= dram_base;
            total_q     <= TW'(num_rams) * TW'(RAM_WORDS);
            issued      <= '0;
            returned    <= '0;
            outstanding <= '0;
            ram_addr    <= '0;
            ram_num     <= ram_base_num;
            state       <= (num_rams == 16'd0) ? S_DONE
                                               : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (abort) begin
            state <= S_FLUSH;
          end else if (issued == total_q) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            state <= S_FLUSH;
          end else if (returned == total_q) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        S_FLUSH: begin
          if (outstanding == '0) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cram_load_scheduler.sv
// Directed bench for cram_load_scheduler with a 2-cycle-latency
// in-order memory responder and write/request monitors.
module tb_cram_load_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [31:0] dram_base;
  logic [31:0] ram_base_num;
  logic [15:0] num_rams;
  logic        rd_req_valid;
  logic        rd_req_ready;
  logic [31:0] rd_req_addr;
  logic        rd_data_valid = 1'b0;
  logic [39:0] rd_data = '0;
  logic [39:0] ram_data_out;
  logic [8:0]  ram_addr;
  logic [31:0] ram_num;
  logic        ram_we;
  logic        busy;
  logic        done;

  cram_load_scheduler dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .abort         (abort),
    .dram_base     (dram_base),
    .ram_base_num  (ram_base_num),
    .num_rams      (num_rams),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .rd_data_valid (rd_data_valid),
    .rd_data       (rd_data),
    .ram_data_out  (ram_data_out),
    .ram_addr      (ram_addr),
    .ram_num       (ram_num),
    .ram_we        (ram_we),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // In-order responder; hold_ret withholds all returns.
  typedef struct {
    logic [31:0] a;
    int          due;
  } ent_t;
  ent_t q[$];
  bit   hold_ret = 1'b0;

  always @(negedge clk) begin
    ent_t e;
    if (!hold_ret && q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      rd_data_valid = 1'b1;
      rd_data = {8'h5A, e.a};
    end else begin
      rd_data_valid = 1'b0;
    end
    if (rd_req_valid && rd_req_ready)
      q.push_back('{rd_req_addr, cyc + 2});
  end

  logic [31:0] exp_dram = '0;
  int exp_num  = 0;
  int req_base = 0;
  int wr_base  = 0;
  int req_cnt  = 0;
  int req_err  = 0;
  int wr_cnt   = 0;
  int wr_err   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_we  = 0;

  always @(negedge clk) begin
    int idx;
    logic [31:0] ea;
    if (rd_req_valid && rd_req_ready) begin
      ea = exp_dram + 32'(req_cnt - req_base);
      if (rd_req_addr !== ea) req_err++;
      req_cnt++;
    end
    if (ram_we) begin
      idx = wr_cnt - wr_base;
      ea  = exp_dram + 32'(idx);
      if (ram_addr !== 9'(idx % 512)) wr_err++;
      if (ram_num !== 32'(exp_num + idx / 512)) wr_err++;
      if (ram_data_out !== {8'h5A, ea}) wr_err++;
      wr_cnt++;
      last_we = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] d, input logic [31:0] b,
                             input logic [15:0] n);
    dram_base    = d;
    ram_base_num = b;
    num_rams     = n;
    start        = 1'b1;
    step(1);
    start        = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int k;
    k = 0;
    while (busy && k < maxc) begin
      step(1);
      k++;
    end
    chk(tag, 64'(busy), 64'd0);
  endtask

  task automatic mark(input logic [31:0] d, input int b);
    exp_dram = d;
    exp_num  = b;
    req_base = req_cnt;
    wr_base  = wr_cnt;
  endtask

  int r0, w0, d0, re0, we0, k, bad;
  logic [31:0] a0;

  initial begin
    resetn       = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    rd_req_ready = 1'b0;
    dram_base    = '0;
    ram_base_num = '0;
    num_rams     = '0;
    step(2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(rd_req_valid), 64'd0);
    chk("rst_we", 64'(ram_we), 64'd0);
    resetn = 1'b1;
    step(1);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_addr", 64'(ram_addr), 64'd0);
    chk("idle_num", 64'(ram_num), 64'd0);
    chk("idle_req_addr", 64'(rd_req_addr), 64'd0);
    chk("idle_data", 64'(ram_data_out), 64'd0);

    // One CRAM, ready always high.
    mark(32'h100, 3);
    r0 = req_cnt; w0 = wr_cnt; d0 = done_cnt;
    re0 = req_err; we0 = wr_err;
    rd_req_ready = 1'b1;
    pulse_start(32'h100, 32'd3, 16'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_idle(2000, "t1_timeout");
    step(2);
    chk("t1_reqs", 64'(req_cnt - r0), 64'd512);
    chk("t1_writes", 64'(wr_cnt - w0), 64'd512);
    chk("t1_req_err", 64'(req_err - re0), 64'd0);
    chk("t1_wr_err", 64'(wr_err - we0), 64'd0);
    chk("t1_done", 64'(done_cnt - d0), 64'd1);
    chk("t1_done_after_we", 64'(done_cyc - last_we), 64'd1);
    chk("t1_end_addr", 64'(ram_addr), 64'd0);
    chk("t1_end_num", 64'(ram_num), 64'd4);

    // Two CRAMs with a start pulse mid-transfer that must be ignored.
    mark(32'h4000, 7);
    r0 = req_cnt; w0 = wr_cnt; d0 = done_cnt;
    re0 = req_err; we0 = wr_err;
    pulse_start(32'h4000, 32'd7, 16'd2);
    step(50);
    pulse_start(32'h0, 32'd99, 16'd5);
    wait_idle(4000, "t2_timeout");
    step(2);
    chk("t2_reqs", 64'(req_cnt - r0), 64'd1024);
    chk("t2_writes", 64'(wr_cnt - w0), 64'd1024);
    chk("t2_req_err", 64'(req_err - re0), 64'd0);
    chk("t2_wr_err", 64'(wr_err - we0), 64'd0);
    chk("t2_done", 64'(done_cnt - d0), 64'd1);
    chk("t2_end_num", 64'(ram_num), 64'd9);

    // Stall: ready low, then data withheld to fill the window.
    mark(32'h8000, 20);
    r0 = req_cnt; w0 = wr_cnt; d0 = done_cnt;
    re0 = req_err; we0 = wr_err;
    rd_req_ready = 1'b0;
    pulse_start(32'h8000, 32'd20, 16'd1);
    chk("t3_valid", 64'(rd_req_valid), 64'd1);
    chk("t3_addr", 64'(rd_req_addr), 64'h8000);
    a0 = rd_req_addr;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (!rd_req_valid || rd_req_addr !== a0) bad++;
    end
    chk("t3_stall_stable", 64'(bad), 64'd0);
    chk("t3_no_req", 64'(req_cnt - r0), 64'd0);
    hold_ret = 1'b1;
    rd_req_ready = 1'b1;
    step(15);
    chk("t3_window", 64'(req_cnt - r0), 64'd8);
    chk("t3_window_valid", 64'(rd_req_valid), 64'd0);
    chk("t3_no_wr", 64'(wr_cnt - w0), 64'd0);
    hold_ret = 1'b0;
    wait_idle(2000, "t3_timeout");
    step(2);
    chk("t3_reqs", 64'(req_cnt - r0), 64'd512);
    chk("t3_writes", 64'(wr_cnt - w0), 64'd512);
    chk("t3_req_err", 64'(req_err - re0), 64'd0);
    chk("t3_wr_err", 64'(wr_err - we0), 64'd0);
    chk("t3_done", 64'(done_cnt - d0), 64'd1);

    // Zero CRAMs: straight to DONE.
    r0 = req_cnt; w0 = wr_cnt; d0 = done_cnt;
    pulse_start(32'h0, 32'd55, 16'd0);
    chk("t5_busy", 64'(busy), 64'd1);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_valid", 64'(rd_req_valid), 64'd0);
    chk("t5_num", 64'(ram_num), 64'd55);
    step(1);
    chk("t5_busy_end", 64'(busy), 64'd0);
    chk("t5_done_end", 64'(done), 64'd0);
    step(3);
    chk("t5_reqs", 64'(req_cnt - r0), 64'd0);
    chk("t5_writes", 64'(wr_cnt - w0), 64'd0);
    chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);

    // Abort with 5 requests in flight.
    mark(32'hC000, 40);
    r0 = req_cnt; w0 = wr_cnt; d0 = done_cnt;
    we0 = wr_err;
    rd_req_ready = 1'b1;
    pulse_start(32'hC000, 32'd40, 16'd1);
    k = 0;
    while (req_cnt - r0 < 95 && k < 500) begin
      step(1);
      k++;
    end
    rd_req_ready = 1'b0;
    step(10);
    chk("t4_writes95", 64'(wr_cnt - w0), 64'd95);
    hold_ret = 1'b1;
    rd_req_ready = 1'b1;
    k = 0;
    while (req_cnt - r0 < 100 && k < 50) begin
      step(1);
      k++;
    end
    rd_req_ready = 1'b0;
    chk("t4_issued100", 64'(req_cnt - r0), 64'd100);
    chk("t4_inflight", 64'(q.size()), 64'd5);
    abort = 1'b1;
    step(1);
    chk("t4_flush_valid", 64'(rd_req_valid), 64'd0);
    chk("t4_flush_busy", 64'(busy), 64'd1);
    hold_ret = 1'b0;
    wait_idle(50, "t4_timeout");
    chk("t4_drained", 64'(q.size()), 64'd0);
    chk("t4_no_flush_wr", 64'(wr_cnt - w0), 64'd95);
    chk("t4_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t4_wr_err", 64'(wr_err - we0), 64'd0);
    abort = 1'b0;
    step(2);

    // Asynchronous reset mid-ISSUE.
    mark(32'h10000, 77);
    rd_req_ready = 1'b1;
    pulse_start(32'h10000, 32'd77, 16'd1);
    step(30);
    chk("t6_pre_busy", 64'(busy), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_valid", 64'(rd_req_valid), 64'd0);
    chk("t6_we", 64'(ram_we), 64'd0);
    chk("t6_addr", 64'(ram_addr), 64'd0);
    chk("t6_num", 64'(ram_num), 64'd0);
    chk("t6_req_addr", 64'(rd_req_addr), 64'd0);
    chk("t6_data", 64'(ram_data_out), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    step(1);
    resetn = 1'b1;
    w0 = wr_cnt;
    r0 = req_cnt;
    step(10);
    chk("t6_idle", 64'(busy), 64'd0);
    chk("t6_stale_ignored", 64'(wr_cnt - w0), 64'd0);
    chk("t6_no_req", 64'(req_cnt - r0), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
